tiny_dnn_seq: RTL and testbench

TINY_DNN_SEQ -- requirements
Module: tiny_dnn_seq

---
 rtl/tiny_dnn_seq_if.sv | 38 +++
 rtl/tiny_dnn_seq.sv | 160 ++++++++++++++++
 tb/tb_tiny_dnn_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_seq_if.sv
// +--------------------------------------------------------------------------+
// | Module      : tiny_dnn_seq_if                                            |
// | Description : Command and core-array control bundle of tiny_dnn_seq.     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tiny_dnn_seq_if;
    logic        start;
    logic [10:0] cfg_base;
    logic [10:0] cfg_len;
    logic        cfg_bias;
    logic        cfg_dwconv;
    logic [5:0]  cfg_outn;

    logic        busy;
    logic        done;
    logic        init;
    logic        exec;
    logic        bias;
    logic        outr;
    logic        update;
    logic        dwconv;
    logic [10:0] ra;
    logic [10:0] ia;

    modport master (
        output start, cfg_base, cfg_len, cfg_bias, cfg_dwconv, cfg_outn,
        input  busy, done, init, exec, bias, outr, update, dwconv, ra, ia
    );

    modport slave (
        input  start, cfg_base, cfg_len, cfg_bias, cfg_dwconv, cfg_outn,
        output busy, done, init, exec, bias, outr, update, dwconv, ra, ia
    );
endinterface

`default_nettype wire

// File: rtl/tiny_dnn_seq.sv
// +--------------------------------------------------------------------------+
// | Module      : tiny_dnn_seq                                               |
// | Description : Command sequencer driving init/exec/bias/drain/out strobes |
// |               of a small DNN core array. Define TINY_DNN_SEQ_ABORT_EN    |
// |               to add the abort input.                                    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tiny_dnn_seq #(
    parameter int F_SIZE  = 1024,
    parameter int OUT_MAX = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
`ifdef TINY_DNN_SEQ_ABORT_EN
    input  wire logic     abort,
`endif
    tiny_dnn_seq_if.slave bus
);

    localparam logic [10:0] c_f_size  = 11'(F_SIZE);
    localparam logic [5:0]  c_out_max = 6'(OUT_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_EXEC  = 3'd2,
        S_BIAS  = 3'd3,
        S_DRAIN = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_cnt;
    logic [10:0] r_base;
    logic [10:0] r_len;
    logic        r_bias;
    logic        r_dwconv;
    logic [5:0]  r_outn;
    logic        w_abort;
    logic        w_accept;

`ifdef TINY_DNN_SEQ_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_cnt restarts at zero on every state change; it indexes EXEC, DRAIN and OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 11'd0;
        end else if ((w_next != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= 11'd0;
        end else begin
            r_cnt <= r_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= 11'd0;
            r_len    <= 11'd0;
            r_bias   <= 1'b0;
            r_dwconv <= 1'b0;
            r_outn   <= 6'd0;
        end else if (w_accept) begin
            r_base   <= bus.cfg_base;
            r_len    <= (bus.cfg_len > c_f_size) ? c_f_size : bus.cfg_len;
            r_bias   <= bus.cfg_bias;
            r_dwconv <= bus.cfg_dwconv;
            r_outn   <= (bus.cfg_outn > c_out_max) ? c_out_max : bus.cfg_outn;
        end
    end

    always_comb begin
        w_next     = r_state;
        bus.busy   = (r_state != S_IDLE);
        bus.done   = 1'b0;
        bus.init   = 1'b0;
        bus.exec   = 1'b0;
        bus.bias   = 1'b0;
        bus.outr   = 1'b0;
        bus.update = 1'b0;
        bus.dwconv = (r_state != S_IDLE) && r_dwconv;
        bus.ra     = 11'd0;
        bus.ia     = 11'd0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                bus.init = 1'b1;
                if (r_len != 11'd0) begin
                    w_next = S_EXEC;
                end else if (r_bias) begin
                    w_next = S_BIAS;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_EXEC: begin
                bus.exec = 1'b1;
                bus.ra   = r_base + r_cnt;
                bus.ia   = r_dwconv ? r_cnt : 11'd0;
                if (r_cnt == (r_len - 11'd1)) begin
                    w_next = r_bias ? S_BIAS : S_DRAIN;
                end
            end
            S_BIAS: begin
                bus.bias = 1'b1;
                bus.ra   = r_base;
                w_next   = S_DRAIN;
            end
            // Two idle cycles let the core's accumulate pipeline settle before OUT.
            S_DRAIN: begin
                if (r_cnt == 11'd1) begin
                    w_next = (r_outn != 6'd0) ? S_OUT : S_DONE;
                end
            end
            S_OUT: begin
                bus.outr   = 1'b1;
                bus.update = (r_cnt == 11'd0);
                if (r_cnt == ({5'd0, r_outn} - 11'd1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tiny_dnn_seq.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_tiny_dnn_seq                                            |
// | Description : Scoreboard bench for tiny_dnn_seq: per-busy-cycle expected |
// |               control vectors queued by stimulus, popped by a monitor.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tiny_dnn_seq;

    typedef struct packed {
        logic        init;
        logic        exec;
        logic        bias;
        logic        outr;
        logic        update;
        logic        dwconv;
        logic        done;
        logic [10:0] ra;
        logic [10:0] ia;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tiny_dnn_seq_if bus ();
`ifdef TINY_DNN_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    tiny_dnn_seq #(.F_SIZE(1024), .OUT_MAX(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef TINY_DNN_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic i, e, b, o, u, d, dn,
                                input logic [10:0] ra, ia);
        exp_t x;
        x.init = i; x.exec = e; x.bias = b; x.outr = o; x.update = u;
        x.dwconv = d; x.done = dn; x.ra = ra; x.ia = ia;
        return x;
    endfunction

    function automatic exp_t actual();
        exp_t x;
        x.init = bus.init; x.exec = bus.exec; x.bias = bus.bias;
        x.outr = bus.outr; x.update = bus.update; x.dwconv = bus.dwconv;
        x.done = bus.done; x.ra = bus.ra; x.ia = bus.ia;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference sequence built directly from the command description.
    task automatic push_cmd(input logic [10:0] base, input int len, input logic b,
                            input logic dw, input int outn);
        int l;
        int o;
        logic [10:0] ra;
        l = (len > 1024) ? 1024 : len;
        o = (outn > 32) ? 32 : outn;
        q.push_back(mk(1, 0, 0, 0, 0, dw, 0, 11'd0, 11'd0));
        for (int k = 0; k < l; k++) begin
            ra = base + 11'(k);
            q.push_back(mk(0, 1, 0, 0, 0, dw, 0, ra, dw ? 11'(k) : 11'd0));
        end
        if (b) q.push_back(mk(0, 0, 1, 0, 0, dw, 0, base, 11'd0));
        repeat (2) q.push_back(mk(0, 0, 0, 0, 0, dw, 0, 11'd0, 11'd0));
        for (int k = 0; k < o; k++) q.push_back(mk(0, 0, 0, 1, (k == 0), dw, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 0, 0, dw, 1, 11'd0, 11'd0));
    endtask

    // Hand-written timeline for base=5, len=3, bias=0, outn=2.
    task automatic push_ref9();
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11'd5, 11'd0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11'd6, 11'd0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11'd7, 11'd0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 11'd0, 11'd0));
    endtask

    task automatic drive_cfg(input logic [10:0] base, input logic [10:0] len,
                             input logic b, input logic dw, input logic [5:0] outn);
        bus.cfg_base = base; bus.cfg_len = len; bus.cfg_bias = b;
        bus.cfg_dwconv = dw; bus.cfg_outn = outn;
    endtask

    task automatic cmd(input logic [10:0] base, input logic [10:0] len,
                       input logic b, input logic dw, input logic [5:0] outn);
        @(posedge clk); #1;
        drive_cfg(base, len, b, dw, outn);
        bus.start = 1'b1;
        push_cmd(base, int'(len), b, dw, int'(outn));
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive_cfg(11'h3AA, 11'd9, 1'b1, 1'b1, 6'd9);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_complete_queue_left", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_busy(input logic v);
        int n;
        n = 0;
        while (bus.busy !== v && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("wait_busy_timeout", 64'(bus.busy), 64'(v));
    endtask

    // Monitor: every busy cycle consumes one expected vector; idle cycles must be all-zero.
    always @(negedge clk) begin
        chk("strobe_exclusive", 64'($countones({bus.init, bus.exec, bus.bias, bus.outr}) <= 1), 64'd1);
        if (bus.busy === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_busy_cycle", 64'(actual()), 64'd0);
            end else begin
                chk("busy_cycle", 64'(actual()), 64'(q.pop_front()));
            end
        end else begin
            chk("idle_outputs", {35'd0, bus.busy, actual()}, 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.start = 1'b0;
        drive_cfg(11'd0, 11'd0, 1'b0, 1'b0, 6'd0);
        #2;
        chk("reset_state", {35'd0, bus.busy, actual()}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reference timeline, hand-computed.
        @(posedge clk); #1;
        drive_cfg(11'h005, 11'd3, 1'b0, 1'b0, 6'd2);
        bus.start = 1'b1;
        push_ref9();
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive_cfg(11'h123, 11'd7, 1'b1, 1'b1, 6'd5);
        wait_drain();

        // Address wrap, depthwise index, bias cycle.
        cmd(11'h7FE, 11'd4, 1'b1, 1'b1, 6'd3);
        wait_drain();
        // Minimal command: INIT, DRAIN x2, DONE.
        cmd(11'h100, 11'd0, 1'b0, 1'b0, 6'd0);
        wait_drain();
        // len=0 going straight to BIAS, single OUT cycle.
        cmd(11'h0A0, 11'd0, 1'b1, 1'b0, 6'd1);
        wait_drain();
        // Clamping of len and outn.
        cmd(11'h400, 11'd2000, 1'b0, 1'b1, 6'd63);
        wait_drain();

        // start held across three commands; cfg changes while busy must not leak in.
        @(posedge clk); #1;
        drive_cfg(11'h010, 11'd2, 1'b1, 1'b0, 6'd1);
        bus.start = 1'b1;
        push_cmd(11'h010, 2, 1'b1, 1'b0, 1);
        push_cmd(11'h020, 1, 1'b0, 1'b1, 2);
        push_cmd(11'h7FF, 2, 1'b0, 1'b0, 0);
        wait_busy(1'b1);
        drive_cfg(11'h020, 11'd1, 1'b0, 1'b1, 6'd2);
        wait_busy(1'b0);
        wait_busy(1'b1);
        drive_cfg(11'h7FF, 11'd2, 1'b0, 1'b0, 6'd0);
        wait_busy(1'b0);
        wait_busy(1'b1);
        bus.start = 1'b0;
        drive_cfg(11'h055, 11'd5, 1'b1, 1'b1, 6'd4);
        wait_drain();

        // Reset in the second EXEC cycle discards the command.
        @(posedge clk); #1;
        drive_cfg(11'h005, 11'd3, 1'b0, 1'b0, 6'd2);
        bus.start = 1'b1;
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11'd5, 11'd0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {35'd0, bus.busy, actual()}, 64'd0);
        chk("reset_discarded_queue", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive_cfg(11'h005, 11'd3, 1'b0, 1'b0, 6'd2);
        bus.start = 1'b1;
        push_ref9();
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_drain();

`ifdef TINY_DNN_SEQ_ABORT_EN
        // Abort in the first OUT cycle: back to IDLE next cycle, no DONE.
        @(posedge clk); #1;
        drive_cfg(11'h000, 11'd1, 1'b0, 1'b0, 6'd3);
        bus.start = 1'b1;
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 11'd0, 11'd0));
        q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 11'd0, 11'd0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_to_idle", 64'(bus.busy), 64'd0);
        wait_drain();
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
